// File: rtl/div_8bit_seq_pkg.sv
// ---------------------------------------------------------------------------
// div_8bit_seq_pkg
// Shared definitions for the sequential 8-bit divider: operand width and the
// FSM state encoding used by div_8bit_seq.
// ---------------------------------------------------------------------------
package div_8bit_seq_pkg;

    // Operand / result width. The datapath and the 3-bit step counter are
    // sized for exactly 8 bits.
    localparam int WIDTH = 8;

    // Width of the step counter: one step per quotient bit.
    localparam int STEP_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : div_8bit_seq_pkg

// File: rtl/div_8bit_seq_sub_9bit.sv
// ---------------------------------------------------------------------------
// sub_9bit
// Combinational 9-bit subtractor used for the divider's trial subtraction.
//
// Ports
//   a      in  9  minuend (shifted partial remainder)
//   b      in  9  subtrahend (zero-extended divisor)
//   diff   out 9  a - b, modulo 2^9
//   borrow out 1  high when a < b (trial subtraction went negative)
// ---------------------------------------------------------------------------
module sub_9bit (
    input  logic [8:0] a,
    input  logic [8:0] b,
    output logic [8:0] diff,
    output logic       borrow
);

    // The extra top bit of the 10-bit difference is the borrow out.
    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule : sub_9bit

// File: rtl/div_8bit_seq.sv
// ---------------------------------------------------------------------------
// div_8bit_seq
// Unsigned restoring divider. One quotient bit is produced per clock, MSB
// first; a division takes 8 RUN cycles followed by a single DONE cycle.
// A divisor of zero takes no special path: it naturally yields
// quotient = 8'hFF and remainder = dividend, flagged by div_zero.
//
// Ports
//   clk       in  1      clock, rising edge
//   rst_n     in  1      asynchronous active-low reset
//   start     in  1      request a division (accepted in IDLE or DONE)
//   dividend  in  WIDTH  unsigned dividend, sampled on the accepting edge
//   divisor   in  WIDTH  unsigned divisor, sampled on the accepting edge
//   busy      out 1      high while the FSM is in RUN
//   done      out 1      one-cycle pulse, results valid
//   quotient  out WIDTH  unsigned quotient (held until the next result)
//   remainder out WIDTH  unsigned remainder (held until the next result)
//   div_zero  out 1      divisor of the current operation was zero
// ---------------------------------------------------------------------------
module div_8bit_seq #(
    parameter int WIDTH = div_8bit_seq_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    import div_8bit_seq_pkg::*;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

    state_t            state;
    logic [STEP_W-1:0] step;

    // dq starts as the dividend: its MSB feeds the partial remainder each
    // step while the new quotient bit enters at the LSB, so after 8 steps it
    // holds the complete quotient.
    logic [WIDTH-1:0]  dq;
    logic [WIDTH-1:0]  divisor_r;

    // 9-bit partial remainder; after a restore or a kept subtraction it is
    // always below the divisor, but the shifted value needs the extra bit.
    logic [WIDTH:0]    prem;
    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    diff;
    logic              borrow;
    logic [WIDTH:0]    rem_next;
    logic [WIDTH-1:0]  q_next;

    // Shift the partial remainder left and bring in the next dividend bit.
    assign shifted = (prem << 1) | (WIDTH+1)'(dq[WIDTH-1]);

    sub_9bit u_sub (
        .a      (shifted),
        .b      ({1'b0, divisor_r}),
        .diff   (diff),
        .borrow (borrow)
    );

    // Non-negative trial result is kept (quotient bit 1); otherwise the
    // shifted value is restored (quotient bit 0).
    assign rem_next = borrow ? shifted : diff;
    assign q_next   = {dq[WIDTH-2:0], ~borrow};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register, including the operand/datapath copies,
            // is reset; the block is tiny and this keeps outputs defined.
            state     <= IDLE;
            step      <= '0;
            dq        <= '0;
            divisor_r <= '0;
            prem      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // done is high only during the DONE cycle itself.
                    done <= 1'b0;
                    if (start) begin
                        dq        <= dividend;
                        divisor_r <= divisor;
                        prem      <= '0;
                        step      <= '0;
                        div_zero  <= (divisor == '0);
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                RUN: begin
                    // start is ignored here; the operation in flight runs on.
                    prem <= rem_next;
                    dq   <= q_next;
                    step <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        quotient  <= q_next;
                        remainder <= rem_next[WIDTH-1:0];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : div_8bit_seq
